// File: rtl/seg_mux_capture.sv
// seg_mux_capture: receive side of a two-digit multiplexed 7-seg driver.
// Samples seg_in on each rising sig_in edge and rebuilds (hi, lo) pairs.
// Checks strobe spacing against PERIOD +/- SLACK and flags lost pairs.
// Ports: clk, rst (sync, active-high), seg_in[6:0] (bit0=a..bit6=g),
//   sig_in (strobe), out_ready (consumer accept), clr_err (clear flags);
//   out_valid, hi_raw/lo_raw[6:0], hi_hex/lo_hex[3:0], hi_ok/lo_ok,
//   synced, timing_err, overrun_err.
module seg_mux_capture #(
  parameter int PERIOD = 15001,
  parameter int SLACK  = 16,
  parameter int CBITS  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       sig_in,
  input  logic       out_ready,
  input  logic       clr_err,
  output logic       out_valid,
  output logic [6:0] hi_raw,
  output logic [6:0] lo_raw,
  output logic [3:0] hi_hex,
  output logic [3:0] lo_hex,
  output logic       hi_ok,
  output logic       lo_ok,
  output logic       synced,
  output logic       timing_err,
  output logic       overrun_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_LO = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;

  localparam logic [CBITS-1:0] EARLY_LIM = CBITS'(PERIOD - SLACK);
  localparam logic [CBITS-1:0] LATE_LIM  = CBITS'(PERIOD + SLACK);

  // {ok, hex}; anything outside the glyph table decodes to 0 / not ok
  function automatic logic [4:0] dec7(input logic [6:0] s);
    logic [4:0] r;
    r = 5'h00;
    case (s)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CBITS-1:0] gap_q, gap_d;
  logic             sig_d_q;
  logic [6:0]       hsh_q, hsh_d;
  logic             vld_q, vld_d;
  logic [6:0]       hraw_q, hraw_d, lraw_q, lraw_d;
  logic [3:0]       hhex_q, hhex_d, lhex_q, lhex_d;
  logic             hok_q, hok_d, lok_q, lok_d;
  logic             sync_q, sync_d;
  logic             terr_q, terr_d;
  logic             oerr_q, oerr_d;

  logic             stb;
  logic             early;
  logic             tmo;
  logic             legal;
  logic             terr_ev;
  logic             pub;
  logic [4:0]       hdec, ldec;

  assign stb   = sig_in & ~sig_d_q;
  assign early = gap_q < EARLY_LIM;
  assign tmo   = gap_q >= LATE_LIM;
  // a strobe landing in the timeout cycle is treated as the timeout
  assign legal = stb & ~early & ~tmo;

  assign hdec = dec7(hsh_q);
  assign ldec = dec7(seg_in);

  always_comb begin
    gap_d = gap_q;
    if (stb)
      gap_d = '0;
    else if (~&gap_q)
      gap_d = gap_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    hsh_d   = hsh_q;
    terr_ev = 1'b0;
    pub     = 1'b0;
    case (state_q)
      IDLE: begin
        if (stb) begin
          hsh_d   = seg_in;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (tmo || (stb && early)) begin
          terr_ev = 1'b1;
          hsh_d   = '0;
          state_d = IDLE;
        end else if (legal) begin
          pub     = 1'b1;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tmo || (stb && early)) begin
          terr_ev = 1'b1;
          state_d = IDLE;
        end else if (legal) begin
          hsh_d   = seg_in;
          state_d = WAIT_LO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hraw_d = hraw_q;
    lraw_d = lraw_q;
    hhex_d = hhex_q;
    lhex_d = lhex_q;
    hok_d  = hok_q;
    lok_d  = lok_q;
    vld_d  = vld_q;
    if (pub) begin
      hraw_d = hsh_q;
      lraw_d = seg_in;
      hhex_d = hdec[3:0];
      lhex_d = ldec[3:0];
      hok_d  = hdec[4];
      lok_d  = ldec[4];
      vld_d  = 1'b1;
    end else if (vld_q && out_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_comb begin
    sync_d = sync_q;
    if (terr_ev)
      sync_d = 1'b0;
    else if (pub)
      sync_d = 1'b1;
    // new events win over a simultaneous clear
    terr_d = terr_ev | (terr_q & ~clr_err);
    oerr_d = (pub & vld_q & ~out_ready) | (oerr_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      sig_d_q <= 1'b0;
      hsh_q   <= '0;
      vld_q   <= 1'b0;
      hraw_q  <= '0;
      lraw_q  <= '0;
      hhex_q  <= '0;
      lhex_q  <= '0;
      hok_q   <= 1'b0;
      lok_q   <= 1'b0;
      sync_q  <= 1'b0;
      terr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      sig_d_q <= sig_in;
      hsh_q   <= hsh_d;
      vld_q   <= vld_d;
      hraw_q  <= hraw_d;
      lraw_q  <= lraw_d;
      hhex_q  <= hhex_d;
      lhex_q  <= lhex_d;
      hok_q   <= hok_d;
      lok_q   <= lok_d;
      sync_q  <= sync_d;
      terr_q  <= terr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign out_valid   = vld_q;
  assign hi_raw      = hraw_q;
  assign lo_raw      = lraw_q;
  assign hi_hex      = hhex_q;
  assign lo_hex      = lhex_q;
  assign hi_ok       = hok_q;
  assign lo_ok       = lok_q;
  assign synced      = sync_q;
  assign timing_err  = terr_q;
  assign overrun_err = oerr_q;

endmodule

// File: tb/tb_seg_mux_capture.sv
// tb_seg_mux_capture: directed bench for seg_mux_capture.
// PERIOD=10, SLACK=2, CBITS=5; drives on negedge, samples on negedge.
module tb_seg_mux_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       sig_in;
  logic       out_ready;
  logic       clr_err;
  logic       out_valid;
  logic [6:0] hi_raw, lo_raw;
  logic [3:0] hi_hex, lo_hex;
  logic       hi_ok, lo_ok;
  logic       synced, timing_err, overrun_err;

  int n_run = 0;
  int n_fail = 0;

  seg_mux_capture #(
    .PERIOD(10),
    .SLACK (2),
    .CBITS (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .sig_in     (sig_in),
    .out_ready  (out_ready),
    .clr_err    (clr_err),
    .out_valid  (out_valid),
    .hi_raw     (hi_raw),
    .lo_raw     (lo_raw),
    .hi_hex     (hi_hex),
    .lo_hex     (lo_hex),
    .hi_ok      (hi_ok),
    .lo_ok      (lo_ok),
    .synced     (synced),
    .timing_err (timing_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one-cycle strobe; returns at the negedge after the sampling edge
  task automatic strobe(input logic [6:0] s);
    seg_in = s;
    sig_in = 1'b1;
    @(negedge clk);
    sig_in = 1'b0;
    seg_in = 7'h00;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic chk_pair(input string tag, input logic [3:0] h,
                          input logic [3:0] l);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".hi"}, 32'(hi_hex), 32'(h));
    chk({tag, ".lo"}, 32'(lo_hex), 32'(l));
  endtask

  initial begin
    rst = 1'b1;
    seg_in = 7'h00;
    sig_in = 1'b0;
    out_ready = 1'b1;
    clr_err = 1'b0;
    idle(3);
    rst = 1'b0;

    // reset state
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.raw", {18'd0, hi_raw, lo_raw}, 32'd0);
    chk("rst.flags", {29'd0, synced, timing_err, overrun_err}, 32'd0);

    // 1: basic pair 06/4F
    idle(2);
    strobe(7'h06);
    idle(9);
    strobe(7'h4F);
    chk_pair("t1", 4'h1, 4'h3);
    chk("t1.ok", {30'd0, hi_ok, lo_ok}, 32'd3);
    chk("t1.raw", {18'd0, hi_raw, lo_raw}, {18'd0, 7'h06, 7'h4F});
    chk("t1.sync", 32'(synced), 32'd1);
    chk("t1.err", {30'd0, timing_err, overrun_err}, 32'd0);
    idle(1);
    chk("t1.drop", 32'(out_valid), 32'd0);

    // 2: continuous stream
    idle(8);
    strobe(7'h3F);
    idle(9);
    strobe(7'h7F);
    chk_pair("t2a", 4'h0, 4'h8);
    idle(9);
    strobe(7'h77);
    idle(9);
    strobe(7'h71);
    chk_pair("t2b", 4'hA, 4'hF);
    chk("t2b.err", {30'd0, timing_err, overrun_err}, 32'd0);

    // 3: early strobe in WAIT_LO
    idle(9);
    strobe(7'h06);
    idle(4);
    strobe(7'h7F);
    chk("t3.terr", 32'(timing_err), 32'd1);
    chk("t3.sync", 32'(synced), 32'd0);
    chk("t3.valid", 32'(out_valid), 32'd0);
    idle(9);
    strobe(7'h5B);
    idle(9);
    strobe(7'h66);
    chk_pair("t3b", 4'h2, 4'h4);
    chk("t3b.sync", 32'(synced), 32'd1);

    // 4: timeout after one pattern, then clear
    clr_pulse();
    chk("t4.clr0", 32'(timing_err), 32'd0);
    idle(8);
    strobe(7'h5B);
    idle(11);
    chk("t4.pre", 32'(timing_err), 32'd0);
    idle(2);
    chk("t4.terr", 32'(timing_err), 32'd1);
    chk("t4.sync", 32'(synced), 32'd0);
    clr_pulse();
    chk("t4.clr", 32'(timing_err), 32'd0);

    // 5: backpressure overrun
    idle(20);
    out_ready = 1'b0;
    strobe(7'h06);
    idle(9);
    strobe(7'h5B);
    chk_pair("t5a", 4'h1, 4'h2);
    chk("t5a.ovr", 32'(overrun_err), 32'd0);
    idle(3);
    chk_pair("t5hold", 4'h1, 4'h2);
    idle(6);
    strobe(7'h07);
    chk_pair("t5hold2", 4'h1, 4'h2);
    idle(9);
    strobe(7'h6F);
    chk_pair("t5b", 4'h7, 4'h9);
    chk("t5b.ovr", 32'(overrun_err), 32'd1);
    out_ready = 1'b1;
    idle(1);
    chk("t5.acc", 32'(out_valid), 32'd0);

    // 6: illegal glyphs, then reset in WAIT_LO
    clr_pulse();
    chk("t6.clr", 32'(overrun_err), 32'd0);
    idle(7);
    strobe(7'h00);
    idle(9);
    strobe(7'h2A);
    chk("t6.valid", 32'(out_valid), 32'd1);
    chk("t6.ok", {30'd0, hi_ok, lo_ok}, 32'd0);
    chk("t6.hex", {24'd0, hi_hex, lo_hex}, 32'd0);
    chk("t6.raw", {18'd0, hi_raw, lo_raw}, {18'd0, 7'h00, 7'h2A});
    idle(9);
    strobe(7'h3F);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6.rraw", {18'd0, hi_raw, lo_raw}, 32'd0);
    chk("t6.rflags", {28'd0, out_valid, synced, timing_err, overrun_err},
        32'd0);
    idle(2);
    strobe(7'h66);
    idle(9);
    strobe(7'h4F);
    chk_pair("t6post", 4'h4, 4'h3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
